decoder_6_to_64_pipe: RTL and testbench

Pipelined 6-to-64 index decoder: the inverse of the team's 64-to-6 priority encoder. It accepts a 6-bit index through a valid/ready handshake and produces a 64-bit one-hot vector plus a 64-bit thermometer mask. The mask supplies the priority-pointer window for the programmable priority encoder path, and the one-hot drives grant and clear vectors. It is built as two registered stages on an 8×8 group split, with full backpressure support.

---
 rtl/ppe_pkg.sv | 22 ++
 rtl/decoder_3_to_8.sv | 22 ++
 rtl/decoder_6_to_64_pipe.sv | 102 ++++++++++
 tb/tb_decoder_6_to_64_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppe_pkg.sv
// Shared constants and payload types for the priority encode/decode path.
package ppe_pkg;

  localparam int unsigned IDX_W   = 6;
  localparam int unsigned GRP_W   = 3;
  localparam int unsigned NUM_GRP = 8;
  localparam int unsigned GRP_SZ  = 8;
  localparam int unsigned VEC_W   = 64;

  localparam logic [VEC_W-1:0] ALL_ONES = '1;

  // Stage A payload: factored group/lane decodes plus the echoed index.
  typedef struct packed {
    logic [NUM_GRP-1:0] grp_oh;
    logic [NUM_GRP-1:0] grp_gt;
    logic [GRP_SZ-1:0]  lo_oh;
    logic [GRP_SZ-1:0]  lo_th;
    logic               en;
    logic [IDX_W-1:0]   idx;
  } stage_a_t;

endpackage

// File: rtl/decoder_3_to_8.sv
// 3-bit to 8-bit one-hot plus thermometer decoder; mirror of the 8-to-3 encoder.
module decoder_3_to_8
  import ppe_pkg::*;
#(
  parameter bit INCL = 1'b1
) (
  input  logic [GRP_W-1:0]   sel,
  output logic [NUM_GRP-1:0] onehot_c,
  output logic [NUM_GRP-1:0] thermo_c
);

  // Per-bit compare against the select; INCL picks k >= sel or k > sel.
  for (genvar k = 0; k < NUM_GRP; k++) begin : g_bit
    assign onehot_c[k] = (sel == GRP_W'(k));
    if (INCL) begin : g_incl
      assign thermo_c[k] = (GRP_W'(k) >= sel);
    end else begin : g_excl
      assign thermo_c[k] = (GRP_W'(k) > sel);
    end
  end

endmodule

// File: rtl/decoder_6_to_64_pipe.sv
// Two-stage pipelined 6-to-64 decoder producing a one-hot and a thermometer mask.
module decoder_6_to_64_pipe
  import ppe_pkg::*;
#(
  parameter bit THERMO_INCL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_onehot,
  output logic [VEC_W-1:0] out_mask,
  output logic [IDX_W-1:0] out_idx
);

  stage_a_t           a_q;
  stage_a_t           a_nxt_c;
  logic               a_valid;
  logic               ready_b_c;
  logic [NUM_GRP-1:0] grp_oh_c;
  logic [NUM_GRP-1:0] grp_gt_c;
  logic [GRP_SZ-1:0]  lo_oh_c;
  logic [GRP_SZ-1:0]  lo_th_c;
  logic [VEC_W-1:0]   onehot_nxt_c;
  logic [VEC_W-1:0]   mask_nxt_c;

  // Backpressure chain: B frees when empty or draining, A frees when B can take it.
  assign ready_b_c = !out_valid || out_ready;
  assign in_ready  = !a_valid || ready_b_c;

  // Group decode uses the strictly-greater window so whole higher groups are set.
  decoder_3_to_8 #(.INCL(1'b0)) u_grp (
    .sel      (in_idx[IDX_W-1:GRP_W]),
    .onehot_c (grp_oh_c),
    .thermo_c (grp_gt_c)
  );

  // Lane decode carries the inclusive/exclusive choice for the index's own group.
  decoder_3_to_8 #(.INCL(THERMO_INCL)) u_lo (
    .sel      (in_idx[GRP_W-1:0]),
    .onehot_c (lo_oh_c),
    .thermo_c (lo_th_c)
  );

  // Assemble the stage A payload from the two small decoders.
  always_comb begin
    a_nxt_c        = '0;
    a_nxt_c.grp_oh = grp_oh_c;
    a_nxt_c.grp_gt = grp_gt_c;
    a_nxt_c.lo_oh  = lo_oh_c;
    a_nxt_c.lo_th  = lo_th_c;
    a_nxt_c.en     = in_en;
    a_nxt_c.idx    = in_idx;
  end

  // Stage A register: valid follows the input whenever A can move.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      a_q     <= '0;
    end else begin
      if (in_ready) begin
        a_valid <= in_valid;
      end
      if (in_valid && in_ready) begin
        a_q <= a_nxt_c;
      end
    end
  end

  // Flat 8x8 AND/OR expansion of the factored group and lane decodes.
  for (genvar j = 0; j < NUM_GRP; j++) begin : g_grp
    for (genvar k = 0; k < GRP_SZ; k++) begin : g_lane
      assign onehot_nxt_c[j*GRP_SZ+k] = a_q.grp_oh[j] & a_q.lo_oh[k];
      assign mask_nxt_c[j*GRP_SZ+k]   = a_q.grp_gt[j] | (a_q.grp_oh[j] & a_q.lo_th[k]);
    end
  end

  // Stage B register: "no index" yields an empty one-hot and a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_mask   <= '0;
      out_idx    <= '0;
    end else begin
      if (ready_b_c) begin
        out_valid <= a_valid;
      end
      if (a_valid && ready_b_c) begin
        out_onehot <= a_q.en ? onehot_nxt_c : '0;
        out_mask   <= a_q.en ? mask_nxt_c : ALL_ONES;
        out_idx    <= a_q.idx;
      end
    end
  end

endmodule

// File: tb/tb_decoder_6_to_64_pipe.sv
// Scoreboard bench for decoder_6_to_64_pipe (inclusive and exclusive instances).
module tb_decoder_6_to_64_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_en, out_ready;
  logic [5:0]  in_idx;
  logic        in_ready, in_ready_x, out_valid, out_valid_x;
  logic [63:0] out_onehot, out_mask, onehot_x, mask_x;
  logic [5:0]  out_idx, idx_x;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int outs = 0;
  bit lat_on = 1'b0;
  bit rand_done = 1'b0;

  typedef struct {
    logic [5:0]  idx;
    logic [63:0] oh;
    logic [63:0] mi;
    logic [63:0] me;
    int          acc_cyc;
    bit          lat;
  } exp_t;

  exp_t sbq[$];

  decoder_6_to_64_pipe #(.THERMO_INCL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_en(in_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_mask(out_mask), .out_idx(out_idx)
  );

  decoder_6_to_64_pipe #(.THERMO_INCL(1'b0)) dut_x (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_x),
    .in_idx(in_idx), .in_en(in_en), .out_valid(out_valid_x), .out_ready(out_ready),
    .out_onehot(onehot_x), .out_mask(mask_x), .out_idx(idx_x)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference: window of all bits at or above idx (or strictly above).
  function automatic exp_t model(input logic [5:0] idx, input logic en, input int c, input bit l);
    exp_t e;
    logic [63:0] ones;
    ones = '1;
    e.idx = idx;
    e.oh = en ? (64'd1 << idx) : 64'd0;
    e.mi = en ? (ones << idx) : ones;
    e.me = en ? (ones << ({1'b0, idx} + 7'd1)) : ones;
    e.acc_cyc = c;
    e.lat = l;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Input monitor: a beat seen valid&ready here transfers on the next edge.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sbq.push_back(model(in_idx, in_en, cyc, lat_on));
  end

  // Output monitor: pop and compare every beat the DUT hands downstream.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      outs++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out got idx=%0d exp=none", out_idx);
      end else begin
        e = sbq.pop_front();
        chk("onehot", out_onehot, e.oh);
        chk("mask_incl", out_mask, e.mi);
        chk("idx", 64'(out_idx), 64'(e.idx));
        chk("valid_excl", 64'(out_valid_x), 64'd1);
        chk("onehot_excl", onehot_x, e.oh);
        chk("mask_excl", mask_x, e.me);
        chk("idx_excl", 64'(idx_x), 64'(e.idx));
        // Transfer edge of the input is acc_cyc+1, output leaves at cyc+1.
        if (e.lat) chk("latency", 64'(cyc - e.acc_cyc), 64'd2);
      end
    end
  end

  task automatic send(input logic [5:0] idx, input logic en);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_idx = idx;
    in_en = en;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout idx=%0d got in_ready=0 exp=1", idx);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 500 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 64'(sbq.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    in_valid = 1'b0;
    in_en = 1'b0;
    in_idx = '0;
    out_ready = 1'b1;

    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_onehot", out_onehot, 64'd0);
    chk("rst_mask", out_mask, 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Corners, mid index, and the no-index case.
    lat_on = 1'b1;
    send(6'd0, 1'b1);
    send(6'd63, 1'b1);
    send(6'd37, 1'b1);
    send(6'd12, 1'b0);
    wait_drain();

    // Back-to-back exhaustive stream.
    base = outs;
    for (int i = 0; i < 64; i++) send(6'(i), 1'b1);
    wait_drain();
    chk("stream_count", 64'(outs - base), 64'd64);

    // Backpressure: two beats fill the pipe, the third stalls.
    lat_on = 1'b0;
    base = outs;
    out_ready = 1'b0;
    send(6'd5, 1'b1);
    send(6'd6, 1'b1);
    in_valid = 1'b1;
    in_idx = 6'd7;
    in_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_onehot", out_onehot, 64'd1 << 5);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6'd7, 1'b1);
    wait_drain();
    chk("bp_count", 64'(outs - base), 64'd3);

    // Reset with a full pipe discards everything immediately.
    out_ready = 1'b0;
    send(6'd20, 1'b1);
    send(6'd21, 1'b1);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_onehot", out_onehot, 64'd0);
    chk("mid_rst_mask", out_mask, 64'd0);
    chk("mid_rst_idx", 64'(out_idx), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    base = outs;
    lat_on = 1'b1;
    send(6'd44, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);
    chk("post_rst_count", 64'(outs - base), 64'd1);

    // Random traffic with random gaps and random downstream stalls.
    lat_on = 1'b0;
    base = outs;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
          end
          send(6'($urandom_range(63)), ($urandom_range(7) != 0));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("rand_count", 64'(outs - base), 64'd300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
